// File: rtl/zeroheti_obi_demux.sv
// zeroheti_obi_demux
// ------------------------------------------------------------------------------------------
// OBI 1-to-NUM_SUB address demultiplexer with a parametrised rule table.
//
// One manager port is decoded against RULES and steered to one of NUM_SUB subordinate ports.
// Addresses that match no rule go to a built-in error responder, which answers one cycle after
// the grant with err=1 and rdata=ERR_RDATA. Up to MAX_OUT transactions may be outstanding, but
// only towards a single target at a time. A request to another target waits until every
// in-flight transaction has completed, so responses always come back in request order.
//
// Parameters
//   NUM_SUB    number of subordinate ports (1..16)
//   MAX_OUT    maximum outstanding transactions (1..15)
//   RULES      per-subordinate half-open range [base, last). Entry i is {last, base}:
//              RULES[i][0] = base, RULES[i][1] = last. On overlap the lowest index wins.
//   ERR_RDATA  read data returned with a decode-miss response
//
// Ports
//   clk_i, rst_i                          clock (rising edge), synchronous active-high reset
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i  manager request channel
//   rvalid_o/rdata_o/err_o                manager response channel
//   sub_req_o[NUM_SUB], sub_gnt_i         per-subordinate request / grant
//   sub_addr_o/we_o/be_o/wdata_o          request payload broadcast to every subordinate
//   sub_rvalid_i, sub_rdata_i, sub_err_i  per-subordinate response (rdata i at [32*i +: 32])
// ------------------------------------------------------------------------------------------
module zeroheti_obi_demux #(
  parameter int unsigned NUM_SUB = 7,
  parameter int unsigned MAX_OUT = 2,
  // Default map, highest index first. Each entry is {last, base}.
  parameter logic [NUM_SUB-1:0][1:0][31:0] RULES = {
    {32'h0003_0000, 32'h0002_0000},  // sub6
    {32'h0002_0000, 32'h0001_0000},  // sub5
    {32'h0000_B000, 32'h0000_A000},  // sub4
    {32'h0000_A000, 32'h0000_9000},  // sub3
    {32'h0000_9000, 32'h0000_5000},  // sub2
    {32'h0000_5000, 32'h0000_1000},  // sub1
    {32'h0000_1000, 32'h0000_0000}   // sub0
  },
  parameter logic [31:0] ERR_RDATA = 32'hBADC_AB1E
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [31:0]             wdata_i,
  output logic                    rvalid_o,
  output logic [31:0]             rdata_o,
  output logic                    err_o,
  output logic [NUM_SUB-1:0]      sub_req_o,
  input  logic [NUM_SUB-1:0]      sub_gnt_i,
  output logic [31:0]             sub_addr_o,
  output logic                    sub_we_o,
  output logic [3:0]              sub_be_o,
  output logic [31:0]             sub_wdata_o,
  input  logic [NUM_SUB-1:0]      sub_rvalid_i,
  input  logic [NUM_SUB*32-1:0]   sub_rdata_i,
  input  logic [NUM_SUB-1:0]      sub_err_i
);

  localparam int unsigned SEL_W = $clog2(NUM_SUB + 1);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Index NUM_SUB is the internal error responder.
  localparam sel_t ERR_SEL = sel_t'(NUM_SUB);
  localparam cnt_t CNT_MAX = cnt_t'(MAX_OUT);

  // State
  cnt_t cnt;
  sel_t cur_sel;
  logic err_pend;

  // Decode
  logic [NUM_SUB-1:0] hit;
  logic [NUM_SUB-1:0] cur_mask;
  sel_t               sel;
  logic               sel_is_err;
  logic               sel_gnt;

  // Response mux
  logic               rsp_sub;
  logic [31:0]        rdata_sub;
  logic               err_sub;
  logic               cur_is_err;
  logic               rsp;
  logic               rsp_fire;

  logic               allow;
  logic               accept;

  generate
    for (genvar gi = 0; gi < NUM_SUB; gi++) begin : g_sub
      assign hit[gi]       = (addr_i >= RULES[gi][0]) && (addr_i < RULES[gi][1]);
      assign sub_req_o[gi] = !rst_i && req_i && allow && (sel == sel_t'(gi));
      // Ports that may legitimately answer right now.
      assign cur_mask[gi]  = (cnt != '0) && (cur_sel == sel_t'(gi));
    end
  endgenerate

  // Priority encode: scanning downwards leaves the lowest matching index in sel.
  always_comb begin
    sel = ERR_SEL;
    for (int i = NUM_SUB - 1; i >= 0; i--) begin
      if (hit[i]) sel = sel_t'(i);
    end
  end

  assign sel_is_err = (sel == ERR_SEL);

  always_comb begin
    sel_gnt = 1'b0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (sel == sel_t'(i)) sel_gnt = sub_gnt_i[i];
    end
  end

  always_comb begin
    rsp_sub   = 1'b0;
    rdata_sub = '0;
    err_sub   = 1'b0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (cur_sel == sel_t'(i)) begin
        rsp_sub   = sub_rvalid_i[i];
        rdata_sub = sub_rdata_i[32*i +: 32];
        err_sub   = sub_err_i[i];
      end
    end
  end

  assign cur_is_err = (cur_sel == ERR_SEL);
  assign rsp        = cur_is_err ? err_pend : rsp_sub;
  // A response only counts while something is in flight; stray valids are dropped here.
  assign rsp_fire   = !rst_i && rsp && (cnt != '0);

  assign rvalid_o   = rsp_fire;
  assign rdata_o    = rsp_fire ? (cur_is_err ? ERR_RDATA : rdata_sub) : '0;
  assign err_o      = rsp_fire ? (cur_is_err ? 1'b1 : err_sub) : 1'b0;

  // Switching target only when the pipe is empty keeps responses in order.
  assign allow      = (cnt == '0) || ((sel == cur_sel) && (cnt < CNT_MAX));
  assign gnt_o      = !rst_i && allow && (sel_gnt || sel_is_err);
  assign accept     = req_i && gnt_o;

  assign sub_addr_o  = addr_i;
  assign sub_we_o    = we_i;
  assign sub_be_o    = be_i;
  assign sub_wdata_o = wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      cur_sel  <= '0;
      err_pend <= 1'b0;
    end else begin
      if (accept) cur_sel <= sel;

      // A new miss re-arms the responder even if the previous miss is answered this cycle.
      if (accept && sel_is_err)          err_pend <= 1'b1;
      else if (rsp_fire && cur_is_err)   err_pend <= 1'b0;

      case ({accept, rsp_fire})
        2'b10:   cnt <= cnt + cnt_t'(1);
        2'b01:   cnt <= cnt - cnt_t'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Protocol checks (simulation only)
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) cnt <= CNT_MAX);
  a_rvalid_cnt: assert property (@(posedge clk_i) disable iff (rst_i) rvalid_o |-> (cnt != '0));
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i) && $stable(be_i) && $stable(wdata_i)));
  a_no_stray: assert property (@(posedge clk_i) disable iff (rst_i) (sub_rvalid_i & ~cur_mask) == '0);

endmodule

// File: tb/tb_zeroheti_obi_demux.sv
// Testbench for zeroheti_obi_demux: directed scenarios followed by a randomized run checked
// against a transaction-level model (rule-table lookup plus an outstanding count and target).
module tb_zeroheti_obi_demux;

  localparam int NS      = 7;
  localparam int MAXO    = 2;
  localparam logic [31:0] ERRD = 32'hBADC_AB1E;
  localparam logic [31:0] RB [NS] = '{32'h0, 32'h1000, 32'h5000, 32'h9000, 32'hA000, 32'h1_0000, 32'h2_0000};
  localparam logic [31:0] RL [NS] = '{32'h1000, 32'h5000, 32'h9000, 32'hA000, 32'hB000, 32'h2_0000, 32'h3_0000};

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_i;
  logic              gnt_o;
  logic [31:0]       addr_i;
  logic              we_i;
  logic [3:0]        be_i;
  logic [31:0]       wdata_i;
  logic              rvalid_o;
  logic [31:0]       rdata_o;
  logic              err_o;
  logic [NS-1:0]     sub_req_o;
  logic [NS-1:0]     sub_gnt_i;
  logic [31:0]       sub_addr_o;
  logic              sub_we_o;
  logic [3:0]        sub_be_o;
  logic [31:0]       sub_wdata_o;
  logic [NS-1:0]     sub_rvalid_i;
  logic [NS*32-1:0]  sub_rdata_i;
  logic [NS-1:0]     sub_err_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  zeroheti_obi_demux dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .sub_req_o(sub_req_o), .sub_gnt_i(sub_gnt_i),
    .sub_addr_o(sub_addr_o), .sub_we_o(sub_we_o), .sub_be_o(sub_be_o), .sub_wdata_o(sub_wdata_o),
    .sub_rvalid_i(sub_rvalid_i), .sub_rdata_i(sub_rdata_i), .sub_err_i(sub_err_i)
  );

  // Reference decode straight from the address map.
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if (a >= RB[i] && a < RL[i]) return i;
    return NS;
  endfunction

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    req_i = 0; addr_i = '0; we_i = 0; be_i = 4'hF; wdata_i = '0;
    sub_gnt_i = '0; sub_rvalid_i = '0; sub_err_i = '0; sub_rdata_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1; idle();
    req_i = 1; addr_i = 32'h1004; sub_gnt_i = '1; sub_rvalid_i = '1;
    #2;
    total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0b want=0", gnt_o); end
    total++; if (sub_req_o !== 7'b0) begin bad++; $display("FAIL rst_subreq got=%b want=0", sub_req_o); end
    total++; if ({rvalid_o, err_o, rdata_o} !== 34'b0) begin bad++; $display("FAIL rst_rsp got=%0b/%0b/%h want=0/0/0", rvalid_o, err_o, rdata_o); end
    step(); step();
    idle(); rst_i = 0;
    #1;
    total++; if (dut.cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", dut.cnt); end
    $display("test_reset done");
  endtask

  task automatic test_read_sub1();
    step(); req_i = 1; addr_i = 32'h1004; sub_gnt_i = 7'b0000010; #1;
    total++; if (sub_req_o !== 7'b0000010) begin bad++; $display("FAIL rd1_subreq got=%b want=0000010", sub_req_o); end
    total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL rd1_gnt got=%0b want=1", gnt_o); end
    step(); idle(); sub_rvalid_i = 7'b0000010; sub_rdata_i[32*1 +: 32] = 32'hDEADBEEF; #1;
    total++; if ({rvalid_o, err_o, rdata_o} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL rd1_rsp got=%0b/%0b/%h want=1/0/deadbeef", rvalid_o, err_o, rdata_o); end
    step(); idle(); #1;
    total++; if (dut.cnt !== 2'd0) begin bad++; $display("FAIL rd1_cnt got=%0d want=0", dut.cnt); end
    total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rd1_quiet got=%0b want=0", rvalid_o); end
    $display("txn read 0x1004 -> sub1 rdata=deadbeef");
  endtask

  task automatic test_err();
    step(); req_i = 1; addr_i = 32'hB000; #1;
    total++; if ({gnt_o, sub_req_o} !== 8'b1000_0000) begin bad++; $display("FAIL err_gnt got=%0b/%b want=1/0000000", gnt_o, sub_req_o); end
    step(); idle(); #1;
    total++; if ({rvalid_o, err_o, rdata_o} !== {1'b1, 1'b1, ERRD}) begin bad++; $display("FAIL err_rsp got=%0b/%0b/%h want=1/1/badcab1e", rvalid_o, err_o, rdata_o); end
    step(); #1;
    total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL err_single got=%0b want=0", rvalid_o); end
    // back-to-back misses
    step(); req_i = 1; addr_i = 32'hB000; #1;
    total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL err_b2b_gnt0 got=%0b want=1", gnt_o); end
    step(); addr_i = 32'hC004; #1;
    total++; if ({gnt_o, rvalid_o, err_o} !== 3'b111) begin bad++; $display("FAIL err_b2b_1 got=%b want=111", {gnt_o, rvalid_o, err_o}); end
    step(); idle(); #1;
    total++; if ({rvalid_o, err_o, rdata_o} !== {1'b1, 1'b1, ERRD}) begin bad++; $display("FAIL err_b2b_2 got=%0b/%0b/%h want=1/1/badcab1e", rvalid_o, err_o, rdata_o); end
    step(); #1;
    total++; if ({rvalid_o, dut.cnt} !== 3'b0) begin bad++; $display("FAIL err_drain got=%0b/%0d want=0/0", rvalid_o, dut.cnt); end
    $display("txn miss 0xB000 and back-to-back misses -> error responses");
  endtask

  task automatic test_max_out();
    step(); req_i = 1; addr_i = 32'h5000; sub_gnt_i = 7'b0000100; #1;
    total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL mo_gnt0 got=%0b want=1", gnt_o); end
    step(); addr_i = 32'h5004; #1;
    total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL mo_gnt1 got=%0b want=1", gnt_o); end
    step(); addr_i = 32'h5008; #1;
    total++; if ({gnt_o, sub_req_o} !== 8'b0) begin bad++; $display("FAIL mo_stall got=%0b/%b want=0/0000000", gnt_o, sub_req_o); end
    total++; if (dut.cnt !== 2'd2) begin bad++; $display("FAIL mo_cnt2 got=%0d want=2", dut.cnt); end
    step(); sub_rvalid_i = 7'b0000100; sub_rdata_i[32*2 +: 32] = 32'h1111_0000; #1;
    total++; if ({gnt_o, rvalid_o, rdata_o} !== {1'b0, 1'b1, 32'h1111_0000}) begin bad++; $display("FAIL mo_rsp0 got=%0b/%0b/%h want=0/1/11110000", gnt_o, rvalid_o, rdata_o); end
    step(); sub_rvalid_i = '0; #1;
    total++; if ({gnt_o, sub_req_o} !== 8'b1000_0100) begin bad++; $display("FAIL mo_release got=%0b/%b want=1/0000100", gnt_o, sub_req_o); end
    step(); idle(); sub_rvalid_i = 7'b0000100; #1;
    step(); #1;
    total++; if (rvalid_o !== 1'b1) begin bad++; $display("FAIL mo_rsp2 got=%0b want=1", rvalid_o); end
    step(); idle(); #1;
    total++; if ({rvalid_o, dut.cnt} !== 3'b0) begin bad++; $display("FAIL mo_drain got=%0b/%0d want=0/0", rvalid_o, dut.cnt); end
    $display("txn three reads to sub2 with MAX_OUT=2 -> third stalled until first response");
  endtask

  task automatic test_switch_target();
    step(); req_i = 1; addr_i = 32'h5000; sub_gnt_i = '1; #1;
    total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL sw_gnt0 got=%0b want=1", gnt_o); end
    step(); addr_i = 32'h9000; #1;
    total++; if ({gnt_o, sub_req_o} !== 8'b0) begin bad++; $display("FAIL sw_stall got=%0b/%b want=0/0000000", gnt_o, sub_req_o); end
    step(); sub_rvalid_i = 7'b0000100; #1;
    total++; if ({gnt_o, rvalid_o} !== 2'b01) begin bad++; $display("FAIL sw_rsp got=%b want=01", {gnt_o, rvalid_o}); end
    step(); sub_rvalid_i = '0; #1;
    total++; if ({gnt_o, sub_req_o} !== 8'b1000_1000) begin bad++; $display("FAIL sw_route got=%0b/%b want=1/0001000", gnt_o, sub_req_o); end
    step(); idle(); sub_rvalid_i = 7'b0001000; sub_err_i = 7'b0001000; sub_rdata_i[32*3 +: 32] = 32'h3333_3333; #1;
    total++; if ({rvalid_o, err_o, rdata_o} !== {1'b1, 1'b1, 32'h3333_3333}) begin bad++; $display("FAIL sw_rsp3 got=%0b/%0b/%h want=1/1/33333333", rvalid_o, err_o, rdata_o); end
    step(); idle(); #1;
    $display("txn sub2 outstanding then 0x9000 -> held, then routed to sub3");
  endtask

  task automatic test_same_cycle_boundary();
    step(); req_i = 1; addr_i = 32'h4FFF; sub_gnt_i = '1; #1;
    total++; if ({gnt_o, sub_req_o} !== 8'b1000_0010) begin bad++; $display("FAIL bd_4fff got=%0b/%b want=1/0000010", gnt_o, sub_req_o); end
    step(); addr_i = 32'h4FF0; sub_rvalid_i = 7'b0000010; #1;
    total++; if ({gnt_o, rvalid_o} !== 2'b11) begin bad++; $display("FAIL sc_both got=%b want=11", {gnt_o, rvalid_o}); end
    step(); idle(); #1;
    total++; if (dut.cnt !== 2'd1) begin bad++; $display("FAIL sc_cnt got=%0d want=1", dut.cnt); end
    sub_rvalid_i = 7'b0000010; step(); idle(); #1;
    total++; if (dut.cnt !== 2'd0) begin bad++; $display("FAIL sc_drain got=%0d want=0", dut.cnt); end
    req_i = 1; addr_i = 32'h5000; sub_gnt_i = '1; #1;
    total++; if ({gnt_o, sub_req_o} !== 8'b1000_0100) begin bad++; $display("FAIL bd_5000 got=%0b/%b want=1/0000100", gnt_o, sub_req_o); end
    step(); idle(); sub_rvalid_i = 7'b0000100; #1;
    step(); idle(); #1;
    $display("txn boundary 0x4FFF->sub1, 0x5000->sub2, accept+response same cycle");
  endtask

  task automatic test_reset_mid();
    step(); req_i = 1; addr_i = 32'h5000; sub_gnt_i = 7'b0000100; #1;
    step(); addr_i = 32'h5004; #1;
    total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL rm_gnt got=%0b want=1", gnt_o); end
    step(); idle(); rst_i = 1; sub_rvalid_i = 7'b0000100; #1;
    total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rm_rv_rst got=%0b want=0", rvalid_o); end
    step(); #1;
    total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rm_rv_late got=%0b want=0", rvalid_o); end
    step(); rst_i = 0; idle(); req_i = 1; addr_i = 32'hA000; sub_gnt_i = '1; #1;
    total++; if ({gnt_o, sub_req_o, rvalid_o} !== 9'b1_0010000_0) begin bad++; $display("FAIL rm_route got=%0b/%b/%0b want=1/0010000/0", gnt_o, sub_req_o, rvalid_o); end
    step(); idle(); sub_rvalid_i = 7'b0010000; sub_rdata_i[32*4 +: 32] = 32'h4444_ABCD; #1;
    total++; if ({rvalid_o, rdata_o} !== {1'b1, 32'h4444_ABCD}) begin bad++; $display("FAIL rm_rsp got=%0b/%h want=1/4444abcd", rvalid_o, rdata_o); end
    step(); idle(); #1;
    $display("txn reset with two in flight, then 0xA000 -> sub4");
  endtask

  task automatic test_random();
    int out_n = 0;
    int cur_t = 0;
    bit pend  = 0;
    int sel;
    bit allowed, exp_gnt, exp_rv, exp_er;
    logic [31:0] exp_rd;
    logic [NS-1:0] exp_req;
    int k;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      sub_rvalid_i = '0; sub_err_i = '0;
      for (int p = 0; p < NS; p++) sub_rdata_i[32*p +: 32] = $urandom;
      exp_rv = 0; exp_er = 0; exp_rd = '0;
      if (out_n > 0) begin
        if (cur_t == NS) begin
          exp_rv = 1; exp_er = 1; exp_rd = ERRD;
        end else if ($urandom_range(0, 1) == 1) begin
          exp_rv = 1;
          exp_er = ($urandom_range(0, 3) == 0);
          sub_rvalid_i[cur_t] = 1'b1;
          sub_err_i[cur_t] = exp_er;
          exp_rd = sub_rdata_i[32*cur_t +: 32];
        end
      end
      if (!pend) begin
        req_i = (cyc < 560) && ($urandom_range(0, 2) != 0);
        k = $urandom_range(0, 8);
        if (k < NS) addr_i = RB[k] + ($urandom % (RL[k] - RB[k]));
        else if (k == NS) addr_i = 32'h0000_B000 + ($urandom % 32'h5000);
        else addr_i = 32'h4000_0000 | $urandom;
        we_i = $urandom_range(0, 1); be_i = 4'($urandom); wdata_i = $urandom;
      end
      sub_gnt_i = NS'($urandom);
      #1;
      sel = decode(addr_i);
      allowed = (out_n == 0) || (sel == cur_t && out_n < MAXO);
      exp_gnt = allowed && ((sel == NS) || sub_gnt_i[sel]);
      exp_req = '0;
      if (req_i && allowed && sel < NS) exp_req[sel] = 1'b1;
      total++; if (gnt_o !== exp_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d addr=%h got=%0b want=%0b", cyc, addr_i, gnt_o, exp_gnt); end
      total++; if (sub_req_o !== exp_req) begin bad++; $display("FAIL rnd_subreq cyc=%0d addr=%h got=%b want=%b", cyc, addr_i, sub_req_o, exp_req); end
      total++; if ({rvalid_o, err_o, rdata_o} !== {exp_rv, exp_er, exp_rd}) begin bad++; $display("FAIL rnd_rsp cyc=%0d got=%0b/%0b/%h want=%0b/%0b/%h", cyc, rvalid_o, err_o, rdata_o, exp_rv, exp_er, exp_rd); end
      total++; if ({sub_addr_o, sub_we_o, sub_be_o, sub_wdata_o} !== {addr_i, we_i, be_i, wdata_i}) begin bad++; $display("FAIL rnd_payload cyc=%0d got=%h want=%h", cyc, sub_addr_o, addr_i); end
      if (exp_rv) out_n--;
      if (req_i && exp_gnt) begin
        out_n++; cur_t = sel;
        $display("txn rnd cyc=%0d addr=%h we=%0b -> target %0d", cyc, addr_i, we_i, sel);
      end
      pend = req_i && !exp_gnt;
    end
    step(); idle(); #1;
    total++; if (dut.cnt !== 2'(out_n)) begin bad++; $display("FAIL rnd_cnt got=%0d want=%0d", dut.cnt, out_n); end
    // let any remaining transactions retire so the bench ends quietly
    for (int d = 0; d < 8 && out_n > 0; d++) begin
      if (cur_t < NS) sub_rvalid_i[cur_t] = 1'b1;
      step(); out_n--; idle(); #1;
    end
  endtask

  initial begin
    test_reset();
    test_read_sub1();
    test_err();
    test_max_out();
    test_switch_target();
    test_same_cycle_boundary();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
